// File: rtl/id_ex_stage.sv
// Purpose : ID/EX pipeline register with load-use hazard stall, branch/jump flush and saturating event counters.
// Latency : 1 cycle ID -> EX; stall is combinational from the ID register fields and the EX register.
// Backpr. : stall holds PC and IF/ID for one cycle while EX takes a bubble; flush squashes the ID instruction.
//
// Ports:
//   clk, rst                 clock (rising edge) and synchronous active-high reset
//   id_*                     decoded control, operands and register fields from ID
//   flush                    taken branch/jump; the ID instruction becomes a bubble
//   stall                    hold PC and IF/ID this cycle (load-use hazard)
//   ex_*                     registered copies of the ID fields presented to EX
//   stall_count/flush_count  saturating counts of stall and flush cycles
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic                  id_reg_write,
    input  logic                  id_reg_dst,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_branch,
    input  logic                  id_jump,
    input  logic                  id_alu_src,
    input  logic                  id_mem_to_reg,
    input  logic [2:0]            id_alu_control,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [DATA_W-1:0]     id_pc_plus4,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  flush,
    output logic                  stall,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_reg_dst,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic                  ex_alu_src,
    output logic                  ex_mem_to_reg,
    output logic [2:0]            ex_alu_control,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [DATA_W-1:0]     ex_pc_plus4,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_write_reg,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [2:0]       ALU_NOP = 3'b100;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  reg_dst;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  alu_src;
        logic                  mem_to_reg;
        logic [2:0]            alu_control;
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     rt_data;
        logic [DATA_W-1:0]     imm;
        logic [DATA_W-1:0]     pc_plus4;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] write_reg;
    } ex_t;

    ex_t              ex_q, ex_d, bubble;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hz;

    // Bubble: nothing valid, no side effects, ALU idle.
    always_comb begin
        bubble             = '0;
        bubble.alu_control = ALU_NOP;
    end

    // A load in EX whose destination is a source of ID must wait one cycle.
    // $0 is never a real dependency, and both source fields are always
    // compared even if the instruction does not read rt.
    always_comb begin
        hz = ex_q.valid & ex_q.mem_read & (ex_q.write_reg != '0) &
             ((ex_q.write_reg == id_rs) | (ex_q.write_reg == id_rt));
    end

    // Flush wins over stall: a squashed instruction has no hazard to wait on.
    assign stall = id_valid & hz & ~flush & ~rst;

    always_comb begin
        ex_d = bubble;
        if (!flush && !stall) begin
            ex_d.valid     = id_valid;
            ex_d.rs_data   = id_rs_data;
            ex_d.rt_data   = id_rt_data;
            ex_d.imm       = id_imm;
            ex_d.pc_plus4  = id_pc_plus4;
            ex_d.rs        = id_rs;
            ex_d.rt        = id_rt;
            ex_d.write_reg = (id_alu_src | id_reg_dst) ? id_rt : id_rd;
            // An invalid ID slot still carries its payload, but must not
            // trigger any EX/MEM/WB side effect.
            if (id_valid) begin
                ex_d.reg_write   = id_reg_write;
                ex_d.reg_dst     = id_reg_dst;
                ex_d.mem_read    = id_mem_read;
                ex_d.mem_write   = id_mem_write;
                ex_d.branch      = id_branch;
                ex_d.jump        = id_jump;
                ex_d.alu_src     = id_alu_src;
                ex_d.mem_to_reg  = id_mem_to_reg;
                ex_d.alu_control = id_alu_control;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= bubble;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid       = ex_q.valid;
    assign ex_reg_write   = ex_q.reg_write;
    assign ex_reg_dst     = ex_q.reg_dst;
    assign ex_mem_read    = ex_q.mem_read;
    assign ex_mem_write   = ex_q.mem_write;
    assign ex_branch      = ex_q.branch;
    assign ex_jump        = ex_q.jump;
    assign ex_alu_src     = ex_q.alu_src;
    assign ex_mem_to_reg  = ex_q.mem_to_reg;
    assign ex_alu_control = ex_q.alu_control;
    assign ex_rs_data     = ex_q.rs_data;
    assign ex_rt_data     = ex_q.rt_data;
    assign ex_imm         = ex_q.imm;
    assign ex_pc_plus4    = ex_q.pc_plus4;
    assign ex_rs          = ex_q.rs;
    assign ex_rt          = ex_q.rt;
    assign ex_write_reg   = ex_q.write_reg;
    assign stall_count    = stall_cnt_q;
    assign flush_count    = flush_cnt_q;

endmodule
